spi_dac_master: RTL and testbench

- 32-bit SPI mode-0 transmit/receive master. Sits directly downstream of the DAC test/counter stage.
- Accepts a parallel command word with a one-cycle start strobe and shifts it MSB-first to the serial DAC.
- Signals completion with a one-cycle done pulse, which the upstream stage uses as its ready/advance input.
- Captures MISO in parallel for DAC readback.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_dac_master_if.sv | 24 ++
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_dac_master.sv | 112 +++++++++++
 tb/tb_spi_dac_master.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared state encoding and DAC command-word constants for the SPI DAC master.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StDone
  } state_e;

  localparam int unsigned DAC_WORD_W = 32;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] ADDR_DAC_A       = 4'b0000;
  localparam logic [7:0] PAD_HI           = 8'hFF;

endpackage

// File: rtl/spi_dac_master_if.sv
// Command/readback handshake and serial pins of the SPI DAC master.
interface spi_dac_master_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] data_in;
  logic              start;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] data_out;

  modport master (
    input  data_in, start, miso,
    output sclk, mosi, cs_n, busy, done, data_out
  );

  modport slave (
    output data_in, start, miso,
    input  sclk, mosi, cs_n, busy, done, data_out
  );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: ticks on the last clk cycle of every CLK_DIV-cycle phase.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CntW   = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] Reload = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Held at the reload value while disabled so every phase starts a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= Reload;
    end else if (!en || cnt_q == '0) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/spi_dac_master.sv
// SPI mode-0 master: shifts one command word MSB-first and captures MISO in parallel.
module spi_dac_master
  import spi_pkg::*;
#(
  parameter int unsigned WORD_W  = DAC_WORD_W,
  parameter int unsigned CLK_DIV = 1
) (
  input logic             clk,
  input logic             reset,
  spi_dac_master_if.master bus
);

  localparam logic [5:0] LastBit = 6'(WORD_W - 1);

  state_e            state_q, state_d;
  logic              tick, div_en, accept, fall;
  logic [WORD_W-1:0] tx_q, rx_q, data_out_q;
  logic [5:0]        bit_cnt_q;
  logic              sclk_q, sclk_d, cs_n_q, cs_n_d, busy_q, busy_d, done_q, done_d;

  assign div_en = state_q inside {StSetup, StShift, StHold};
  assign accept = (state_q == StIdle) && bus.start;
  // Falls happen at the end of a high phase; the datapath moves only on these edges.
  assign fall   = (state_q == StShift) && tick && sclk_q;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .reset(reset),
    .en   (div_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StSetup;
      StSetup: if (tick) state_d = StShift;
      StShift: if (fall && bit_cnt_q == LastBit) state_d = StHold;
      StHold:  if (tick) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    cs_n_d = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    sclk_d = 1'b0;
    unique case (state_d)
      StSetup, StHold: begin
        cs_n_d = 1'b0;
        busy_d = 1'b1;
      end
      StShift: begin
        cs_n_d = 1'b0;
        busy_d = 1'b1;
        sclk_d = tick ? ~sclk_q : sclk_q;
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
      busy_q <= busy_d;
      done_q <= done_d;
      if (accept) begin
        tx_q      <= bus.data_in;
        bit_cnt_q <= '0;
      end else if (fall) begin
        tx_q      <= {tx_q[WORD_W-2:0], 1'b0};
        rx_q      <= {rx_q[WORD_W-2:0], bus.miso};
        bit_cnt_q <= bit_cnt_q + 6'd1;
      end
      if (state_d == StDone) begin
        data_out_q <= rx_q;
      end
    end
  end

  assign bus.sclk     = sclk_q;
  assign bus.mosi     = tx_q[WORD_W-1];
  assign bus.cs_n     = cs_n_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_spi_dac_master.sv
// Scoreboarded bench: D=1 instance against a slave model, D=4 instance in MOSI loopback.
module tb_spi_dac_master;
  import spi_pkg::*;

  localparam int Lat1    = (2 * 32 + 1) * 1 + 1;
  localparam int Period1 = (2 * 32 + 1) * 1 + 2;

  typedef struct {
    logic [31:0] tx;
    logic [31:0] rx;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  exp_t sb_q[$];
  int   next_free = 0;
  int   acc_n = 0;

  logic [31:0] slv_sr = '0;
  int          slv_n = 0;

  logic [31:0] mon_cap = '0;
  int          mon_rises = 0;
  logic        mon_sclk_prev = 1'b0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_exp = '0;

  spi_dac_master_if #(.WORD_W(32)) bus1 ();
  spi_dac_master_if #(.WORD_W(32)) bus4 ();

  spi_dac_master #(.WORD_W(32), .CLK_DIV(1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));
  spi_dac_master #(.WORD_W(32), .CLK_DIV(4)) dut4 (.clk(clk), .reset(rst), .bus(bus4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] slave_word(input int n);
    return 32'h1234_5678 + 32'(n) * 32'h9E37_79B9;
  endfunction

  // Slave presents its MSB while selected and advances after every SCK fall.
  always @(negedge bus1.cs_n) begin
    slv_sr = slave_word(slv_n);
    slv_n++;
  end
  always @(negedge bus1.sclk) slv_sr <= slv_sr << 1;
  assign bus1.miso = slv_sr[31];
  assign bus4.miso = bus4.mosi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one cycle; the model accepts a start only once the previous transfer has fully ended.
  task automatic drive(input logic s, input logic [31:0] d);
    exp_t e;
    bus1.start   = s;
    bus1.data_in = d;
    if (s && !rst && cyc >= next_free) begin
      e.tx       = d;
      e.rx       = slave_word(acc_n);
      e.done_cyc = cyc + Lat1;
      sb_q.push_back(e);
      acc_n++;
      next_free = cyc + Period1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      drive(1'b0, $urandom);
      n++;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
    drive(1'b0, '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus1.sclk && !mon_sclk_prev) begin
        mon_cap = {mon_cap[30:0], bus1.mosi};
        mon_rises++;
      end
      if (bus1.done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 32'(bus1.done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("data_out", bus1.data_out, e.rx);
          check("mosi_word", mon_cap, e.tx);
          check("rise_count", 32'(mon_rises), 32'd32);
          check("cs_n_at_done", 32'(bus1.cs_n), 32'd1);
          check("busy_at_done", 32'(bus1.busy), 32'd0);
          hold_exp   = e.rx;
          hold_valid = 1'b1;
        end
      end else if (hold_valid && !bus1.busy) begin
        check("data_out_hold", bus1.data_out, hold_exp);
      end
      if (bus1.cs_n) begin
        mon_cap   = '0;
        mon_rises = 0;
      end
    end
    mon_sclk_prev = bus1.sclk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   t0, rises, t4;
    logic prev_s;
    int   cs_low, first_rise, last_fall, cs_rise, done4, last_edge, bad_runs, rises4;
    logic prev4;
    logic [31:0] cap4, dout4;

    rst = 1'b1;
    bus1.start = 1'b0;
    bus1.data_in = '0;
    bus4.start = 1'b0;
    bus4.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(bus1.cs_n), 32'd1);
    check("rst_sclk", 32'(bus1.sclk), 32'd0);
    check("rst_mosi", 32'(bus1.mosi), 32'd0);
    check("rst_busy", 32'(bus1.busy), 32'd0);
    check("rst_done", 32'(bus1.done), 32'd0);
    check("rst_data_out", bus1.data_out, 32'd0);
    rst = 1'b0;
    drive(1'b0, '0);

    // Directed word with starts during busy and in the DONE cycle, then a restart.
    t0 = cyc;
    drive(1'b1, 32'hFF30_ABCF);
    check("cs_n_after_start", 32'(bus1.cs_n), 32'd0);
    check("mosi_setup_msb", 32'(bus1.mosi), 32'd1);
    repeat (9) drive(1'b0, $urandom);
    drive(1'b1, $urandom);
    repeat (55) drive(1'b0, $urandom);
    check("done_window", 32'(cyc - t0), 32'd66);
    drive(1'b1, $urandom);
    drive(1'b1, 32'hA5C3_0F96);
    check("restart_cs_n", 32'(bus1.cs_n), 32'd0);
    drive(1'b0, '0);
    drain();

    for (int i = 0; i < 1000; i++) drive($urandom_range(0, 7) == 0, $urandom);
    drain();

    // Asynchronous reset after the 10th SCK rise.
    drive(1'b1, $urandom);
    drive(1'b0, $urandom);
    rises  = 0;
    prev_s = 1'b0;
    for (int i = 0; i < 200 && rises < 10; i++) begin
      @(negedge clk);
      if (bus1.sclk && !prev_s) rises++;
      prev_s = bus1.sclk;
    end
    check("rises_before_reset", 32'(rises), 32'd10);
    #2;
    rst = 1'b1;
    sb_q.delete();
    hold_valid = 1'b0;
    #1;
    check("abort_cs_n", 32'(bus1.cs_n), 32'd1);
    check("abort_sclk", 32'(bus1.sclk), 32'd0);
    check("abort_busy", 32'(bus1.busy), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, '0);
    drive(1'b0, '0);
    rst = 1'b0;
    next_free = 0;
    drive(1'b1, $urandom);
    drain();

    // Start held high with a command word that changes every cycle.
    for (int i = 0; i < 135; i++) drive(1'b1, {CMD_WRITE_UPDATE, ADDR_DAC_A, 16'($urandom), PAD_HI});
    drive(1'b0, '0);
    drain();

    // D=4 instance: phase lengths, setup/hold and loopback readback.
    t4 = cyc;
    bus4.data_in = 32'hFF30_ABCF;
    bus4.start   = 1'b1;
    @(posedge clk);
    #1;
    bus4.start   = 1'b0;
    bus4.data_in = $urandom;
    cs_low = -1; first_rise = -1; last_fall = -1; cs_rise = -1; done4 = -1;
    last_edge = -1; bad_runs = 0; rises4 = 0; prev4 = 1'b0; cap4 = '0; dout4 = '0;
    for (int i = 0; i < 400 && done4 < 0; i++) begin
      @(negedge clk);
      if (cs_low < 0 && !bus4.cs_n) cs_low = cyc;
      if (bus4.sclk != prev4) begin
        if (last_edge >= 0 && cyc - last_edge != 4) bad_runs++;
        last_edge = cyc;
        if (bus4.sclk) begin
          rises4++;
          cap4 = {cap4[30:0], bus4.mosi};
          if (first_rise < 0) first_rise = cyc;
        end else begin
          last_fall = cyc;
        end
      end
      prev4 = bus4.sclk;
      if (cs_low >= 0 && bus4.cs_n && cs_rise < 0) cs_rise = cyc;
      if (bus4.done) begin
        done4 = cyc;
        dout4 = bus4.data_out;
      end
    end
    check("d4_cs_low", 32'(cs_low), 32'(t4 + 1));
    check("d4_setup", 32'(first_rise - cs_low), 32'd4);
    check("d4_bad_levels", 32'(bad_runs), 32'd0);
    check("d4_rises", 32'(rises4), 32'd32);
    check("d4_mosi_word", cap4, 32'hFF30_ABCF);
    check("d4_hold", 32'(cs_rise - last_fall), 32'd4);
    check("d4_done_cycle", 32'(done4), 32'(t4 + 261));
    check("d4_data_out", dout4, 32'hFF30_ABCF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
